obi_cache_regif_pipelined: RTL
==============================

Name: obi_cache_regif_pipelined

Overview:
Parametrised successor of the cache's OBI register front-end. It sits between the CPU-side OBI subordinate port and the cache controller. It adds a response FIFO, so several requests can be in flight and the master can apply backpressure through rready. It also adds address/busy error responses, key read-back, a self-clearing start command, a sticky done flag and an interrupt.

Parameters:
DataWidth, 32, OBI data width; a power of two, at least 32.
AddrWidth, 32, OBI address width.
IdWidth, 1, OBI aid/rid width.
RegDataWidth, 64, cache value width; DataWords = ceil(RegDataWidth/DataWidth), at most 16.
RegKeyWidth, 64, cache key width; KeyWords = ceil(RegKeyWidth/DataWidth), at most 16.
OpWidth, 3, operation code width.
RspDepth, 2, response FIFO depth, at least 1.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_i  in  1  OBI request
gnt_o  out  1  OBI grant
addr_i  in  AddrWidth  byte address
we_i  in  1  write enable
be_i  in  DataWidth/8  byte enables
wdata_i  in  DataWidth  write data
aid_i  in  IdWidth  request id
rvalid_o  out  1  response valid
rready_i  in  1  master ready for response
rdata_o  out  DataWidth  read data
rid_o  out  IdWidth  response id
err_o  out  1  response error
op_o  out  OpWidth  CTRL.op
key_o  out  RegKeyWidth  KEY register
data_o  out  RegDataWidth  DAT register
start_o  out  1  one-cycle command pulse
busy_i  in  1  controller busy
done_i  in  1  one-cycle completion pulse
hit_i  in  1  hit result, sampled on done_i
rdata_valid_i  in  1  controller value write strobe
rdata_i  in  RegDataWidth  controller value
irq_o  out  1  interrupt

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: DAT, KEY, CTRL and STATUS are 0; FIFO is empty; rvalid_o, gnt_o (no req), start_o and irq_o are 0; rdata_o, rid_o and err_o are 0.
- Word address: W = addr_i >> log2(DataWidth/8).
- Register map:
  - DAT: W 0..DataWords-1, RW.
  - KEY: W 16..16+KeyWords-1, RW.
  - CTRL (W 32): bit0 start (write-1, reads 0); bits[OpWidth:1] op; bit OpWidth+1 irq_en.
  - STATUS (W 33): bit0 busy_i (live); bit1 hit; bit2 done (sticky, write-1-to-clear); read-only otherwise.
- Byte enables: writes to DAT, KEY and CTRL honour be_i per byte. Word k of a register maps to bits [k*DataWidth +: DataWidth]. Bits beyond RegDataWidth or RegKeyWidth are dropped on write and read as 0.
- Grant: gnt_o = req_i && (count < RspDepth || pop), where pop = rvalid_o && rready_i. The rready_i to gnt_o path is combinational by design.
- Accept (req_i && gnt_o): register effects and read data are evaluated in the accept cycle. {rdata, aid, err} is pushed into the FIFO. The earliest rvalid_o is the next cycle, so latency is 1 with an empty FIFO.
- Response output: rvalid_o = FIFO not empty. The head entry drives rdata_o, rid_o and err_o and stays stable until popped. Responses return in order. Push and pop in the same cycle keep count unchanged, including when the FIFO is full.
- Error responses (err=1, no register side effect, rdata=0):
  - unmapped W;
  - write to DAT, KEY or CTRL while busy_i=1.
  - STATUS writes are never errors.
  - Reads never error if the address is mapped.
- Write responses: rdata=0.
- Start pulse: a non-error CTRL write with be_i[0] and wdata[0]=1 updates op and asserts start_o for exactly one cycle, in the cycle after acceptance.
- Controller side:
  - rdata_valid_i loads DAT with rdata_i.
  - A same-cycle OBI DAT write is overridden by the controller (controller wins).
  - done_i sets STATUS.done and loads STATUS.hit from hit_i.
  - done_i and a W1C of done in the same cycle leave done=1 (set wins).
- Interrupt: irq_o = STATUS.done && CTRL.irq_en, registered (one cycle after the flag changes).
- Outputs: op_o, key_o and data_o are direct register outputs.
- Reset mid-transaction: the FIFO is flushed, in-flight responses are discarded and all registers are cleared.

Test Plan:
- Reset, then write DAT word0=0xDEADBEEF with be=4'b0011, then read it → rdata 0x0000BEEF, rvalid 1 cycle after grant, err=0, rid equals aid.
- Hold rready_i=0 and issue 3 back-to-back reads with RspDepth=2 → 2 grants, then gnt_o=0. Raise rready_i → third grant in the same cycle as the first pop. Responses arrive in order with ids 0,1,0.
- Write CTRL=0x5 (op=2, start) → start_o high exactly one cycle. With busy_i=1, a KEY write → err=1 and KEY unchanged.
- Read W=40 (unmapped) → err=1, rdata=0. Reading KEY word1 after writing 0x12345678 → 0x12345678.
- Set irq_en, pulse done_i with hit_i=1 → STATUS reads 0x6, irq_o=1. W1C STATUS bit2 in the same cycle as a second done_i → done stays 1. A later W1C alone → irq_o drops 1 cycle later.
- Assert rst with 2 responses queued → next cycle rvalid_o=0, all registers read 0.

Source files
------------

// File: rtl/obi_cache_regif_pipelined.sv
// OBI register front-end for the cache controller: DAT/KEY/CTRL/STATUS map,
// in-order response FIFO with rready backpressure, start pulse, sticky done and irq.
module obi_cache_regif_pipelined #(
   parameter int DataWidth    = 32,
   parameter int AddrWidth    = 32,
   parameter int IdWidth      = 1,
   parameter int RegDataWidth = 64,
   parameter int RegKeyWidth  = 64,
   parameter int OpWidth      = 3,
   parameter int RspDepth     = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [AddrWidth-1:0]    addr_i,
   input  logic                    we_i,
   input  logic [DataWidth/8-1:0]  be_i,
   input  logic [DataWidth-1:0]    wdata_i,
   input  logic [IdWidth-1:0]      aid_i,
   output logic                    rvalid_o,
   input  logic                    rready_i,
   output logic [DataWidth-1:0]    rdata_o,
   output logic [IdWidth-1:0]      rid_o,
   output logic                    err_o,
   output logic [OpWidth-1:0]      op_o,
   output logic [RegKeyWidth-1:0]  key_o,
   output logic [RegDataWidth-1:0] data_o,
   output logic                    start_o,
   input  logic                    busy_i,
   input  logic                    done_i,
   input  logic                    hit_i,
   input  logic                    rdata_valid_i,
   input  logic [RegDataWidth-1:0] rdata_i,
   output logic                    irq_o
);

   localparam int BeWidth   = DataWidth / 8;
   localparam int AddrLsb   = $clog2(BeWidth);
   localparam int DataWords = (RegDataWidth + DataWidth - 1) / DataWidth;
   localparam int KeyWords  = (RegKeyWidth + DataWidth - 1) / DataWidth;
   localparam int DatPadW   = DataWords * DataWidth;
   localparam int KeyPadW   = KeyWords * DataWidth;
   localparam int PtrW      = (RspDepth > 1) ? $clog2(RspDepth) : 1;
   localparam int CntW      = $clog2(RspDepth + 1);

   localparam logic [DatPadW-1:0]   DatMask  = DatPadW'({RegDataWidth{1'b1}});
   localparam logic [KeyPadW-1:0]   KeyMask  = KeyPadW'({RegKeyWidth{1'b1}});
   localparam logic [AddrWidth-1:0] DatEnd   = AddrWidth'(DataWords);
   localparam logic [AddrWidth-1:0] KeyBase  = AddrWidth'(16);
   localparam logic [AddrWidth-1:0] KeyEnd   = AddrWidth'(16 + KeyWords);
   localparam logic [AddrWidth-1:0] CtrlAddr = AddrWidth'(32);
   localparam logic [AddrWidth-1:0] StatAddr = AddrWidth'(33);

   function automatic logic [DataWidth-1:0] merge_bytes(input logic [DataWidth-1:0] old_w,
                                                        input logic [DataWidth-1:0] new_w,
                                                        input logic [BeWidth-1:0]   be);
      merge_bytes = old_w;
      for (int b = 0; b < BeWidth; b++) begin
         if (be[b]) merge_bytes[b*8 +: 8] = new_w[b*8 +: 8];
      end
   endfunction

   function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
      ptr_next = (ptr == PtrW'(RspDepth - 1)) ? '0 : ptr + PtrW'(1);
   endfunction

   logic [DatPadW-1:0]   dat_q, dat_d;
   logic [KeyPadW-1:0]   key_q, key_d;
   logic [OpWidth-1:0]   op_q;
   logic                 irq_en_q, done_q, hit_q;

   logic [DataWidth-1:0] fifo_rdata [RspDepth];
   logic [IdWidth-1:0]   fifo_id    [RspDepth];
   logic                 fifo_err   [RspDepth];
   logic [PtrW-1:0]      rd_ptr, wr_ptr;
   logic [CntW-1:0]      count;

   logic [AddrWidth-1:0] word;
   logic [3:0]           widx;
   logic                 is_dat, is_key, is_ctrl, is_stat, mapped;
   logic                 err, pop, accept, wr_ok;
   logic [DataWidth-1:0] rd_word, wr_word, rsp_rdata;

   assign pop    = rvalid_o && rready_i;
   // rready_i reaches gnt_o combinationally so a full FIFO can accept while draining
   assign gnt_o  = req_i && ((count < CntW'(RspDepth)) || pop);
   assign accept = req_i && gnt_o;
   assign wr_ok  = accept && we_i && !err;

   always_comb begin
      word    = addr_i >> AddrLsb;
      widx    = word[3:0];
      is_dat  = word < DatEnd;
      is_key  = (word >= KeyBase) && (word < KeyEnd);
      is_ctrl = word == CtrlAddr;
      is_stat = word == StatAddr;
      mapped  = is_dat || is_key || is_ctrl || is_stat;
      err     = !mapped || (we_i && busy_i && !is_stat);

      rd_word = '0;
      if (is_dat) begin
         for (int k = 0; k < DataWords; k++)
            if (widx == 4'(k)) rd_word = dat_q[k*DataWidth +: DataWidth];
      end else if (is_key) begin
         for (int k = 0; k < KeyWords; k++)
            if (widx == 4'(k)) rd_word = key_q[k*DataWidth +: DataWidth];
      end else if (is_ctrl) begin
         rd_word = DataWidth'({irq_en_q, op_q, 1'b0});
      end else if (is_stat) begin
         rd_word = DataWidth'({done_q, hit_q, busy_i});
      end

      wr_word   = merge_bytes(rd_word, wdata_i, be_i);
      rsp_rdata = (we_i || err) ? '0 : rd_word;

      dat_d = dat_q;
      key_d = key_q;
      for (int k = 0; k < DataWords; k++)
         if (wr_ok && is_dat && widx == 4'(k)) dat_d[k*DataWidth +: DataWidth] = wr_word;
      for (int k = 0; k < KeyWords; k++)
         if (wr_ok && is_key && widx == 4'(k)) key_d[k*DataWidth +: DataWidth] = wr_word;
      dat_d = dat_d & DatMask;
      key_d = key_d & KeyMask;
      // controller load takes priority over a same-cycle bus write
      if (rdata_valid_i) dat_d = DatPadW'(rdata_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dat_q    <= '0;
         key_q    <= '0;
         op_q     <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         hit_q    <= 1'b0;
         start_o  <= 1'b0;
         irq_o    <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         dat_q <= dat_d;
         key_q <= key_d;
         if (wr_ok && is_ctrl) begin
            op_q     <= wr_word[OpWidth:1];
            irq_en_q <= wr_word[OpWidth+1];
         end
         start_o <= wr_ok && is_ctrl && be_i[0] && wdata_i[0];
         if (done_i) begin
            done_q <= 1'b1;
            hit_q  <= hit_i;
         end else if (wr_ok && is_stat && be_i[0] && wdata_i[2]) begin
            done_q <= 1'b0;
         end
         irq_o <= done_q && irq_en_q;
         if (accept) wr_ptr <= ptr_next(wr_ptr);
         if (pop) rd_ptr <= ptr_next(rd_ptr);
         if (accept && !pop) count <= count + CntW'(1);
         else if (!accept && pop) count <= count - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         fifo_rdata[wr_ptr] <= rsp_rdata;
         fifo_id[wr_ptr]    <= aid_i;
         fifo_err[wr_ptr]   <= err;
      end
   end

   assign rvalid_o = count != '0;
   assign rdata_o  = rvalid_o ? fifo_rdata[rd_ptr] : '0;
   assign rid_o    = rvalid_o ? fifo_id[rd_ptr] : '0;
   assign err_o    = rvalid_o ? fifo_err[rd_ptr] : 1'b0;

   assign op_o   = op_q;
   assign key_o  = key_q[RegKeyWidth-1:0];
   assign data_o = dat_q[RegDataWidth-1:0];

endmodule
